// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor. One full-adder slice and one carry flop
// process the operands LSB first, one bit per clock, so a WIDTH-bit result
// takes WIDTH RUN cycles. Subtraction is a + ~b + 1: the B operand is
// inverted at load time and the carry flop is seeded with 1.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request; accepted in IDLE or DONE (ignored while busy)
//   mode       0 = add (a+b), 1 = subtract (a-b); sampled with start
//   a, b       WIDTH-bit operands; sampled with start
//   busy       high while a computation is in progress (RUN)
//   done       single-cycle pulse when the result registers are updated
//   sum        WIDTH-bit result, held until the next completion
//   carry_out  add: final carry; subtract: 1 = no borrow (a >= b unsigned)
//   overflow   two's-complement signed overflow of the operation
// ---------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  // Bit counter only has to reach WIDTH-1; keep it at least one bit wide.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Full-adder slice: sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Full-adder slice: carry out (majority of the three inputs).
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic             bit_s;
  logic             carry_nxt_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] b_load_s;
  logic             last_s;
  logic             accept_s;

  // Datapath: one full-adder slice plus the partial-result shift.
  always_comb begin
    bit_s       = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
    carry_nxt_s = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);
    // New result bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
    acc_nxt_s            = acc_r >> 1'b1;
    acc_nxt_s[WIDTH-1]   = bit_s;
    b_load_s    = mode ? ~b : b;
    last_s      = (cnt_r == LAST_BIT);
    // DONE accepts a new request just like IDLE, giving back-to-back operation.
    accept_s    = start & ((state_r == S_IDLE) | (state_r == S_DONE));
  end

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE: begin
        if (accept_s) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Controller state, operand shifters, carry flop and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        S_IDLE, S_DONE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b_load_s;
            // Carry seed of 1 completes the two's-complement negation of b.
            carry_r <= mode;
            cnt_r   <= '0;
            acc_r   <= '0;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        S_RUN: begin
          a_sh_r  <= a_sh_r >> 1'b1;
          b_sh_r  <= b_sh_r >> 1'b1;
          carry_r <= carry_nxt_s;
          acc_r   <= acc_nxt_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            sum_r  <= acc_nxt_s;
            cout_r <= carry_nxt_s;
            // On the MSB slice carry_r is the carry into the MSB; signed
            // overflow is that carry differing from the carry out.
            ovf_r  <= carry_r ^ carry_nxt_s;
          end else begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign sum       = sum_r;
  assign carry_out = cout_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//
// Scoreboard bench for serial_addsub. Two instances: WIDTH=8 and WIDTH=1.
// The driver pushes the hand-computed expected result (with the cycle in
// which done must appear) when a request is issued; a separate monitor pops
// and compares whenever done is seen, and also checks how long busy was high.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, mode8, busy8, done8, co8, ov8;
  logic [7:0] a8, b8, sum8;
  logic       rst1, start1, mode1, busy1, done1, co1, ov1;
  logic [0:0] a1, b1, sum1;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
  );

  serial_addsub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .mode(mode1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1), .overflow(ov1)
  );

  typedef struct {
    logic [7:0] sum;
    logic       co;
    logic       ov;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int bc8 = 0;
  int bc1 = 0;

  // Edge counter: after rising edge k (sampled #1 later or at the next
  // falling edge) cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller is at a falling edge. Returns just after the start edge T0.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic m,
                        input logic [7:0] es, input logic eco, input logic eov,
                        output int t0);
    a8 = av; b8 = bv; mode8 = m; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    t0 = cyc;
    q8.push_back(exp_t'{sum: es, co: eco, ov: eov, cyc: t0 + 8});
  endtask

  // A start pulse that must be ignored (issued while busy).
  task automatic pulse8(input logic [7:0] av, input logic [7:0] bv, input logic m);
    a8 = av; b8 = bv; mode8 = m; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic issue1(input logic av, input logic bv, input logic m,
                        input logic es, input logic eco, input logic eov);
    a1 = av; b1 = bv; mode1 = m; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = ~av; b1 = ~bv; mode1 = ~m;
    q1.push_back(exp_t'{sum: {7'd0, es}, co: eco, ov: eov, cyc: cyc + 1});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain8();
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      chk("drain8_timeout", 64'(q8.size()), 64'd0);
      q8.delete();
    end
  endtask

  task automatic drain1();
    for (int i = 0; i < 20 && q1.size() != 0; i++) @(negedge clk);
    if (q1.size() != 0) begin
      chk("drain1_timeout", 64'(q1.size()), 64'd0);
      q1.delete();
    end
  endtask

  // Monitor: compare on every done pulse, count busy cycles per operation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst8) begin
        bc8 = 0;
      end else begin
        if (busy8) bc8++;
        if (done8) begin
          if (q8.size() == 0) begin
            chk("done8_unexpected", 64'd1, 64'd0);
          end else begin
            e = q8.pop_front();
            chk("sum8", 64'(sum8), 64'(e.sum));
            chk("carry_out8", 64'(co8), 64'(e.co));
            chk("overflow8", 64'(ov8), 64'(e.ov));
            chk("done8_cycle", 64'(cyc), 64'(e.cyc));
            chk("busy8_cycles", 64'(bc8), 64'd8);
          end
          bc8 = 0;
        end
      end
      if (rst1) begin
        bc1 = 0;
      end else begin
        if (busy1) bc1++;
        if (done1) begin
          if (q1.size() == 0) begin
            chk("done1_unexpected", 64'd1, 64'd0);
          end else begin
            e = q1.pop_front();
            chk("sum1", 64'(sum1), 64'(e.sum));
            chk("carry_out1", 64'(co1), 64'(e.co));
            chk("overflow1", 64'(ov1), 64'(e.ov));
            chk("done1_cycle", 64'(cyc), 64'(e.cyc));
            chk("busy1_cycles", 64'(bc1), 64'd1);
          end
          bc1 = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // WIDTH=1 table: a, b, mode -> sum, carry_out, overflow (hand-computed).
  logic [5:0] w1_tab [8] = '{
    6'b000_000, 6'b010_100, 6'b100_100, 6'b110_011,
    6'b001_010, 6'b011_101, 6'b101_110, 6'b111_010
  };

  initial begin
    int t0;
    logic [5:0] v;
    rst8 = 1'b1; rst1 = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; mode8 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; mode1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy8", 64'(busy8), 64'd0);
    chk("reset_done8", 64'(done8), 64'd0);
    chk("reset_sum8", 64'(sum8), 64'd0);
    chk("reset_co8", 64'(co8), 64'd0);
    chk("reset_ov8", 64'(ov8), 64'd0);
    chk("reset_busy1", 64'(busy1), 64'd0);
    chk("reset_sum1", 64'(sum1), 64'd0);
    rst8 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    // Basic add/subtract vectors.
    issue8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, t0); drain8();
    repeat (3) @(negedge clk);
    chk("hold_sum8", 64'(sum8), 64'h10);
    chk("idle_busy8", 64'(busy8), 64'd0);
    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, t0); drain8();
    issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, t0); drain8();
    issue8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, t0); drain8();
    issue8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, t0); drain8();

    // Start pulses while busy are ignored; start in DONE is accepted.
    issue8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, t0);
    wait_cyc(t0 + 2);
    chk("busy8_mid_run", 64'(busy8), 64'd1);
    pulse8(8'hFF, 8'hFF, 1'b1);
    wait_cyc(t0 + 5);
    pulse8(8'hFF, 8'hFF, 1'b1);
    wait_cyc(t0 + 8);
    chk("done8_in_done_cycle", 64'(done8), 64'd1);
    issue8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, t0);
    drain8();

    // Reset mid-operation clears outputs asynchronously, no done afterwards.
    issue8(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, t0);
    wait_cyc(t0 + 4);
    chk("busy8_before_rst", 64'(busy8), 64'd1);
    chk("sum8_before_rst", 64'(sum8), 64'h02);
    rst8 = 1'b1;
    #1;
    chk("async_rst_busy8", 64'(busy8), 64'd0);
    chk("async_rst_done8", 64'(done8), 64'd0);
    chk("async_rst_sum8", 64'(sum8), 64'd0);
    chk("async_rst_co8", 64'(co8), 64'd0);
    chk("async_rst_ov8", 64'(ov8), 64'd0);
    q8.delete();
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_sum8", 64'(sum8), 64'd0);
    chk("post_rst_busy8", 64'(busy8), 64'd0);
    issue8(8'h3C, 8'h0A, 1'b1, 8'h32, 1'b1, 1'b0, t0); drain8();
    issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, t0); drain8();

    // WIDTH=1: full-adder truth table with cin = mode.
    for (int i = 0; i < 8; i++) begin
      v = w1_tab[i];
      issue1(v[5], v[4], v[3], v[2], v[1], v[0]);
      drain1();
    end

    repeat (3) @(negedge clk);
    chk("queues_empty", 64'(q8.size() + q1.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
